decoder_rr_arbiter: RTL and testbench
=====================================

# decoder_rr_arbiter

Round-robin arbiter that shares the 4-to-16 binary decoder's one-hot output lines among up to 16 requesters. It selects one requester and drives the decoder's 4-bit select and top-level enable (`en416`), and mirrors the resulting one-hot grant. It enforces break-before-make between owners and a maximum hold time. It sits directly in front of the 4-to-16 decoder, replacing static drive of its select/enable inputs.

## Interface
- `HOLD_MAX`, 8, maximum consecutive GRANT cycles per ownership; legal range 1..255
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  16  level request per requester; bit i = requester i
- `sel`  out  4  registered index of current owner; drives decoder `{d,c,b,a}`
- `en`  out  1  registered decoder enable; drives `en416`
- `grant`  out  16  registered one-hot grant, equal to `en ? (1 << sel) : 0`
- `busy`  out  1  high while in GRANT or RECOVER

## Operation
- FSM states: IDLE, GRANT, RECOVER.
- Round-robin pointer `last` (4 bits) holds the index of the most recent owner.
- Search order starts at `last+1` and proceeds upward with wrap (mod 16). The first set `req` bit wins.
- **IDLE:** `en=0`, `grant=0`. If `req != 0`, go to GRANT with `sel` and `last` set to the winner, `en=1`, and hold counter cleared to 0.
- **GRANT:** `en=1`. The hold counter increments each cycle.
  - Exit to RECOVER when `req[sel]==0` or the hold counter reaches `HOLD_MAX-1` (timeout).
  - On exit: `en=0`, `grant=0`; `sel` keeps its value.
- **RECOVER:** exactly one cycle with `en=0`. This is the break-before-make gap.
  - Re-arbitrate using the same search rule from `last+1`.
  - If any request is present, go to GRANT with the new winner; otherwise go to IDLE.
  - A timed-out requester still holding `req` wins again only if no other bit is set.
- `sel` holds its last value whenever `en=0`. Only `grant` and `en` are meaningful as ownership indicators.
- Counter width is 8 bits. It saturates and never wraps, because timeout fires first.
- `req` changes in non-owner bits during GRANT have no effect until the next arbitration.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled upstream) sets:
  - state = IDLE
  - `sel = 4'd0`, `en = 0`, `grant = 16'h0000`, `busy = 0`
  - `last = 4'd15`, so the first search starts at requester 0
  - hold counter = 0
- Reset mid-GRANT drops `en` and `grant` immediately (asynchronously). There is no RECOVER cycle.
- Grant latency: `req` sampled at edge k; `en`, `sel`, `grant` valid after edge k (visible in cycle k+1).
- Release: `req[sel]` low at edge k, so `en=0` in cycle k+1 (RECOVER) and a new owner is visible in cycle k+2.
- Maximum ownership is `HOLD_MAX` cycles of `en=1`, then at least 1 cycle of `en=0`.
- `HOLD_MAX=1`: every grant lasts one cycle, and grants alternate with RECOVER.
- Worst-case wait for a persistently requesting line is `15*(HOLD_MAX+1)` cycles.
- A request that is dropped and re-raised within the same cycle as its own release is treated as released.

## Structure
- Package `decoder_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, GRANT, RECOVER} arb_state_t`
  - `localparam int N_REQ = 16`
  - `localparam int IDX_W = 4`
  - `localparam int CNT_W = 8`
- Sub-module `rr_priority_pick`: purely combinational. Inputs are `req[15:0]` and `last[3:0]`; outputs are `found` and `idx[3:0]` (rotate, priority-encode, un-rotate).
- The top holds the FSM, pointer, counter, and output registers. `grant` is decoded locally so it can be compared against the decoder's own `f` output in system benches.

## Test plan
- After reset, `req=16'h0020` held: cycle 1 gives `sel=5`, `en=1`, `grant=16'h0020`. Drop `req` → next cycle `en=0`, `grant=0`, `busy=1`; the cycle after, `busy=0`.
- After reset, `req=16'h0208` held throughout, `HOLD_MAX=4`: owner 3 for 4 cycles, 1 gap, owner 9 for 4 cycles, 1 gap, owner 3 again.
- `req=16'hFFFF` held, `HOLD_MAX=1`: `sel` sequence is 0,1,2,…,15,0 with `en` alternating 1,0; `grant` is never non-zero in two consecutive cycles.
- `HOLD_MAX=3`, only `req[7]` held: grants repeat as 3 cycles on / 1 cycle off, with `sel=7` every time.
- Owner 2 active, `req` becomes `16'h0001` while `req[2]` drops: RECOVER, then `sel=0` (wrap from `last=2`) granted.
- Assert `rst_n=0` mid-GRANT with `sel=11`: `en`, `grant`, and `busy` go to 0 without a clock edge. After release with `req=16'h0800`, `sel=11` is granted one cycle later.

Source files
------------

// File: rtl/decoder_arb_pkg.sv
// Shared types, widths and helpers for the round-robin decoder arbiter.
package decoder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECOVER
    } arb_state_t;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    // One-hot line driven by the 4-to-16 decoder for a given select index.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after last+1, with wrap.
module rr_priority_pick
    import decoder_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0]   start;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;

    // Rotate so bit 0 of rot is requester last+1.
    always_comb begin
        start = last + IDX_W'(1);
        dbl   = {req, req};
        rot   = dbl[start +: N_REQ];
    end

    // Lowest set bit of the rotated vector wins; descending loop lets it overwrite.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    always_comb begin
        found = |req;
        idx   = start + off;
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter driving the 4-to-16 decoder select/enable with
// break-before-make between owners and a bounded hold time.
module decoder_rr_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] sel,
    output logic             en,
    output logic [N_REQ-1:0] grant,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] sel_d;
    logic             en_d;
    logic [N_REQ-1:0] grant_d;
    logic             busy_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    rr_priority_pick u_pick (
        .req   (req),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
            sel     <= '0;
            en      <= 1'b0;
            grant   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel     <= sel_d;
            en      <= en_d;
            grant   <= grant_d;
            busy    <= busy_d;
        end
    end

    // Next-state and next-output logic; sel keeps its value whenever en drops.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel_d   = sel;
        en_d    = en;
        grant_d = grant;
        busy_d  = busy;

        case (state_q)
            IDLE, RECOVER: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    grant_d = idx_to_onehot(pick_idx);
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (!req[sel] || (cnt_q == HOLD_LAST)) begin
                    state_d = RECOVER;
                    en_d    = 1'b0;
                    grant_d = '0;
                    busy_d  = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench: four arbiters with different hold limits against an
// ownership-level reference model, plus hand-computed directed expectations.
module tb_decoder_rr_arbiter;

    localparam int NI = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] req_v   [NI];
    logic [3:0]  sel_o   [NI];
    logic        en_o    [NI];
    logic [15:0] grant_o [NI];
    logic        busy_o  [NI];

    int hold_of [NI] = '{8, 4, 1, 3};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.HOLD_MAX(8)) u0 (.clk(clk), .rst_n(rst_n), .req(req_v[0]),
        .sel(sel_o[0]), .en(en_o[0]), .grant(grant_o[0]), .busy(busy_o[0]));
    decoder_rr_arbiter #(.HOLD_MAX(4)) u1 (.clk(clk), .rst_n(rst_n), .req(req_v[1]),
        .sel(sel_o[1]), .en(en_o[1]), .grant(grant_o[1]), .busy(busy_o[1]));
    decoder_rr_arbiter #(.HOLD_MAX(1)) u2 (.clk(clk), .rst_n(rst_n), .req(req_v[2]),
        .sel(sel_o[2]), .en(en_o[2]), .grant(grant_o[2]), .busy(busy_o[2]));
    decoder_rr_arbiter #(.HOLD_MAX(3)) u3 (.clk(clk), .rst_n(rst_n), .req(req_v[3]),
        .sel(sel_o[3]), .en(en_o[3]), .grant(grant_o[3]), .busy(busy_o[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 when none), cycles owned, gap flag, pointer.
    int m_owner [NI] = '{-1, -1, -1, -1};
    int m_held  [NI] = '{0, 0, 0, 0};
    int m_last  [NI] = '{15, 15, 15, 15};
    int m_sel   [NI] = '{0, 0, 0, 0};
    bit m_gap   [NI] = '{0, 0, 0, 0};

    function automatic int first_from(input logic [15:0] r, input int last);
        for (int k = 1; k <= 16; k++) begin
            int j;
            j = (last + k) % 16;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_owner[i] = -1; m_held[i] = 0; m_last[i] = 15; m_sel[i] = 0; m_gap[i] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (m_owner[i] >= 0) begin
                    m_held[i]++;
                    if (!req_v[i][m_owner[i]] || m_held[i] >= hold_of[i]) begin
                        m_owner[i] = -1;
                        m_gap[i]   = 1;
                    end
                end else begin
                    int w;
                    w = first_from(req_v[i], m_last[i]);
                    m_gap[i] = 0;
                    if (w >= 0) begin
                        m_owner[i] = w; m_sel[i] = w; m_last[i] = w; m_held[i] = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [15:0] eg;
            eg = (m_owner[i] >= 0) ? (16'(1) << m_owner[i]) : 16'h0;
            check($sformatf("model u%0d en", i), 32'(en_o[i]), 32'(m_owner[i] >= 0));
            check($sformatf("model u%0d sel", i), 32'(sel_o[i]), 32'(m_sel[i]));
            check($sformatf("model u%0d grant", i), 32'(grant_o[i]), 32'(eg));
            check($sformatf("model u%0d busy", i), 32'(busy_o[i]), 32'((m_owner[i] >= 0) || m_gap[i]));
        end
    end

    task automatic expect_out(input int i, input int c, input int s, input bit e, input bit b);
        string p;
        p = $sformatf("dir c%0d u%0d", c, i);
        check({p, " sel"}, 32'(sel_o[i]), 32'(s));
        check({p, " en"}, 32'(en_o[i]), 32'(e));
        check({p, " grant"}, 32'(grant_o[i]), e ? 32'(16'(1) << s) : 32'h0);
        check({p, " busy"}, 32'(busy_o[i]), 32'(b));
    endtask

    initial begin
        for (int i = 0; i < NI; i++) req_v[i] = 16'h0;
        #1 rst_n = 1'b0;
        req_v[0] = 16'h0020;
        req_v[1] = 16'h0208;
        req_v[2] = 16'hFFFF;
        req_v[3] = 16'h0080;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) expect_out(i, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed window: cycle c is the one visible after the c-th edge past reset.
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #2;
            if (c == 2) req_v[0] = 16'h0000;
            if (c == 5) req_v[0] = 16'h0004;
            if (c == 7) req_v[0] = 16'h0001;
            @(negedge clk);
            #1;
            case (c)
                1, 2:           expect_out(0, c, 5, 1'b1, 1'b1);
                3:              expect_out(0, c, 5, 1'b0, 1'b1);
                4, 5:           expect_out(0, c, 5, 1'b0, 1'b0);
                6, 7:           expect_out(0, c, 2, 1'b1, 1'b1);
                8:              expect_out(0, c, 2, 1'b0, 1'b1);
                default:        expect_out(0, c, 0, 1'b1, 1'b1);
            endcase
            expect_out(1, c, (c <= 5) ? 3 : ((c <= 10) ? 9 : 3), (c != 5) && (c != 10), 1'b1);
            expect_out(2, c, ((c - 1) / 2) % 16, (c % 2) == 1, 1'b1);
            expect_out(3, c, 7, ((c - 1) % 4) != 3, 1'b1);
        end

        // Asynchronous reset while owner 11 holds the decoder.
        @(posedge clk);
        #2 req_v[0] = 16'h0800;
        repeat (3) @(negedge clk);
        #1 expect_out(0, 100, 11, 1'b1, 1'b1);
        #1 rst_n = 1'b0;
        #1 expect_out(0, 101, 0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 expect_out(0, 102, 11, 1'b1, 1'b1);

        // Randomized phase; "keep" is the most likely choice so holds reach timeout.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #2;
            rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < NI; i++) begin
                case ($urandom_range(0, 9))
                    0:       req_v[i] = 16'h0;
                    1:       req_v[i] = 16'($urandom);
                    2:       req_v[i] = 16'(1) << $urandom_range(0, 15);
                    3:       req_v[i] = req_v[i] ^ (16'(1) << $urandom_range(0, 15));
                    4:       req_v[i] = 16'($urandom) & 16'($urandom);
                    default: req_v[i] = req_v[i];
                endcase
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
